// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller.
//   - N_IN_DEFAULT : default number of mux inputs (mux16)
//   - state_e      : controller FSM states (IDLE -> SCAN -> HOLD -> IDLE)
//   - sel_in_range : window bound check done in full int width, so a
//                    SEL_W-bit select is compared against N_IN without truncation
package mux_scan_ctrl_pkg;

  localparam int N_IN_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic sel_in_range(input int sel, input int n_in);
    return (sel < n_in);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_sel_wrap_cnt.sv
// sel_wrap_cnt: loadable select counter that wraps at N_IN-1.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (count and last -> 0)
//   load     in   load count from load_val and latch last_val as the end mark
//   load_val in   SEL_W  start channel
//   last_val in   SEL_W  end channel, latched with load
//   inc      in   advance count by one, wrapping N_IN-1 -> 0 (ignored when load)
//   cnt      out  SEL_W  current count (registered)
//   at_last  out  count equals the latched end mark
module sel_wrap_cnt
  import mux_scan_ctrl_pkg::*;
#(
  parameter int  N_IN  = N_IN_DEFAULT,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic [SEL_W-1:0] last_val,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt,
  output logic             at_last
);

  localparam logic [SEL_W-1:0] TOP = SEL_W'(N_IN - 1);

  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load) begin
      cnt_d  = load_val;
      last_d = last_val;
    end else if (inc) begin
      // N_IN need not be a power of two, so the wrap is explicit.
      cnt_d = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_last = (cnt_q == last_q);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer driving the select of an N_IN:1 mux across a
// programmable channel window, sampling the mux output each cycle and
// offering the packed word on a valid/ready port.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   request a scan (only honoured in IDLE)
//   first_sel   in   SEL_W  first channel of the window
//   last_sel    in   SEL_W  last channel of the window (may wrap below first)
//   s           out  SEL_W  registered select to the mux
//   mux_out     in   mux output, combinational from s
//   busy        out  high while scanning or holding a result
//   data        out  N_IN   captured word; bit i = mux_out sampled while s==i
//   data_valid  out  data offered and stable
//   data_ready  in   consumer accepts when data_valid && data_ready
//   done        out  one-cycle pulse after the word is accepted
//   err         out  one-cycle pulse when a start is rejected (channel >= N_IN)
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int  N_IN  = N_IN_DEFAULT,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] first_sel,
  input  logic [SEL_W-1:0] last_sel,
  output logic [SEL_W-1:0] s,
  input  logic             mux_out,
  output logic             busy,
  output logic [N_IN-1:0]  data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             done,
  output logic             err
);

  state_e            state_q;
  logic [N_IN-1:0]   data_q;
  logic              busy_q;
  logic              data_valid_q;
  logic              done_q;
  logic              err_q;

  logic              window_ok;
  logic              cnt_load;
  logic              cnt_inc;
  logic              at_last;
  logic [SEL_W-1:0]  sel_cnt;

  assign window_ok = sel_in_range(int'(first_sel), N_IN) &&
                     sel_in_range(int'(last_sel), N_IN);

  // The counter owns s: it is loaded on an accepted start and advanced
  // every SCAN cycle except the one that samples the last channel, so s
  // stays on the last channel through HOLD and the following IDLE.
  assign cnt_load = (state_q == ST_IDLE) && start && window_ok;
  assign cnt_inc  = (state_q == ST_SCAN) && !at_last;

  sel_wrap_cnt #(
    .N_IN (N_IN)
  ) u_sel_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (first_sel),
    .last_val (last_sel),
    .inc      (cnt_inc),
    .cnt      (sel_cnt),
    .at_last  (at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (window_ok) begin
              // Clearing here makes channels outside the window read 0.
              data_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_SCAN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          for (int i = 0; i < N_IN; i++) begin
            if (sel_cnt == SEL_W'(i)) begin
              data_q[i] <= mux_out;
            end
          end
          if (at_last) begin
            data_valid_q <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (data_ready) begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s          = sel_cnt;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
